vc_switch: RTL and testbench

Parametrised successor of the two-VC, two-destination flow-control datapath. A single block contains:
- one main input FIFO;
- `NUM_VC = 2**VC_BITS` virtual-channel FIFOs;
- `NUM_DEST = 2**DEST_BITS` destination FIFOs;
- an init/idle/active/error control FSM;
- a round-robin VC-to-destination arbiter, which replaces the earlier fixed VC0-first priority.

It sits between the external packet source and the destination consumers. It exports `pause`, per-destination empty/valid flags and sticky per-FIFO error flags.

---
 rtl/vc_switch.sv | 225 ++++++++++++++++++++++
 tb/tb_vc_switch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vc_switch.sv
// Packet switch: main FIFO feeding per-VC FIFOs, round-robin arbitrated into per-destination FIFOs.
// All FIFOs are first-word-fall-through; transfers run only while the control FSM is IDLE or ACTIVE.
module vc_switch #(
  parameter int DATA_W     = 6,
  parameter int VC_BITS    = 1,
  parameter int DEST_BITS  = 1,
  parameter int MAIN_DEPTH = 8,
  parameter int VC_DEPTH   = 16,
  parameter int D_DEPTH    = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       init,
  input  logic [$clog2(MAIN_DEPTH):0]                af_main_i,
  input  logic [$clog2(VC_DEPTH):0]                  af_vc_i,
  input  logic [$clog2(D_DEPTH):0]                   af_d_i,
  input  logic [DATA_W-1:0]                          data_in,
  input  logic                                       push_main,
  input  logic [(2**DEST_BITS)-1:0]                  pop_d,
  output logic                                       pause,
  output logic [(2**DEST_BITS)-1:0]                  empty_d,
  output logic [(2**DEST_BITS)*DATA_W-1:0]           data_out,
  output logic [(2**DEST_BITS)-1:0]                  valid_out,
  output logic [(2**VC_BITS)+(2**DEST_BITS):0]       error_out,
  output logic [2:0]                                 state_out,
  output logic                                       active_out,
  output logic                                       idle_out
);
  localparam int NUM_VC   = 2**VC_BITS;
  localparam int NUM_DEST = 2**DEST_BITS;
  localparam int MA_W     = $clog2(MAIN_DEPTH);
  localparam int VA_W     = $clog2(VC_DEPTH);
  localparam int DA_W     = $clog2(D_DEPTH);
  localparam int ERR_W    = 1 + NUM_VC + NUM_DEST;
  localparam logic [MA_W:0] MAIN_FULL = (MA_W+1)'(MAIN_DEPTH);
  localparam logic [VA_W:0] VC_FULL   = (VA_W+1)'(VC_DEPTH);
  localparam logic [DA_W:0] D_FULL    = (DA_W+1)'(D_DEPTH);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [MA_W:0]         af_main_r;
  logic [VA_W:0]         af_vc_r;
  logic [DA_W:0]         af_d_r;

  logic [DATA_W-1:0]     main_mem_r [MAIN_DEPTH];
  logic [MA_W-1:0]       main_rd_r, main_wr_r;
  logic [MA_W:0]         main_cnt_r;
  logic [DATA_W-1:0]     vc_mem_r [NUM_VC][VC_DEPTH];
  logic [VA_W-1:0]       vc_rd_r [NUM_VC];
  logic [VA_W-1:0]       vc_wr_r [NUM_VC];
  logic [VA_W:0]         vc_cnt_r [NUM_VC];
  logic [DATA_W-1:0]     d_mem_r [NUM_DEST][D_DEPTH];
  logic [DA_W-1:0]       d_rd_r [NUM_DEST];
  logic [DA_W-1:0]       d_wr_r [NUM_DEST];
  logic [DA_W:0]         d_cnt_r [NUM_DEST];

  logic [VC_BITS-1:0]    rr_ptr_r;
  logic                  pause_r;
  logic [NUM_DEST*DATA_W-1:0] data_out_r;
  logic [NUM_DEST-1:0]   valid_r;
  logic [ERR_W-1:0]      error_r;

  logic                  xfer_en_s, any_ne_s;
  logic [DATA_W-1:0]     main_head_s;
  logic [VC_BITS-1:0]    m2v_vc_s;
  logic                  main_pop_s, main_push_ok_s;
  logic [DATA_W-1:0]     vc_head_s [NUM_VC];
  logic [DEST_BITS-1:0]  vc_dest_s [NUM_VC];
  logic [NUM_VC-1:0]     elig_s, vc_pop_s, vc_push_ok_s;
  logic [VC_BITS-1:0]    rr_idx_s, grant_vc_s;
  logic                  grant_valid_s, take_s;
  logic [DEST_BITS-1:0]  grant_dest_s;
  logic [DATA_W-1:0]     grant_word_s;
  logic [DATA_W-1:0]     d_head_s [NUM_DEST];
  logic [NUM_DEST-1:0]   d_pop_s, d_push_ok_s, empty_s;
  logic [ERR_W-1:0]      err_set_s;

  // Datapath control: routing, round-robin grant, push/pop acceptance and error detection.
  always_comb begin
    xfer_en_s      = (state_r == ST_IDLE) || (state_r == ST_ACTIVE);
    main_head_s    = main_mem_r[main_rd_r];
    m2v_vc_s       = main_head_s[DATA_W-1 -: VC_BITS];
    main_pop_s     = xfer_en_s && (main_cnt_r != '0) && (vc_cnt_r[m2v_vc_s] < af_vc_r);
    main_push_ok_s = xfer_en_s && push_main && ((main_cnt_r != MAIN_FULL) || main_pop_s);
    err_set_s      = '0;
    err_set_s[0]   = xfer_en_s && push_main && (main_cnt_r == MAIN_FULL) && !main_pop_s;
    any_ne_s       = (main_cnt_r != '0);
    for (int v = 0; v < NUM_VC; v++) begin
      vc_head_s[v] = vc_mem_r[v][vc_rd_r[v]];
      vc_dest_s[v] = vc_head_s[v][DATA_W-1-VC_BITS -: DEST_BITS];
      elig_s[v]    = xfer_en_s && (vc_cnt_r[v] != '0) && (d_cnt_r[vc_dest_s[v]] < af_d_r);
      any_ne_s     = any_ne_s || (vc_cnt_r[v] != '0);
    end
    // Cyclic search starting at rr_ptr; the first eligible VC wins.
    grant_valid_s = 1'b0;
    grant_vc_s    = '0;
    rr_idx_s      = '0;
    take_s        = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      rr_idx_s      = rr_ptr_r + VC_BITS'(i);
      take_s        = !grant_valid_s && elig_s[rr_idx_s];
      grant_vc_s    = take_s ? rr_idx_s : grant_vc_s;
      grant_valid_s = grant_valid_s | take_s;
    end
    grant_dest_s = vc_dest_s[grant_vc_s];
    grant_word_s = vc_head_s[grant_vc_s];
    for (int v = 0; v < NUM_VC; v++) begin
      vc_pop_s[v]      = grant_valid_s && (grant_vc_s == VC_BITS'(v));
      vc_push_ok_s[v]  = main_pop_s && (m2v_vc_s == VC_BITS'(v)) &&
                         ((vc_cnt_r[v] != VC_FULL) || vc_pop_s[v]);
      err_set_s[1+v]   = main_pop_s && (m2v_vc_s == VC_BITS'(v)) &&
                         (vc_cnt_r[v] == VC_FULL) && !vc_pop_s[v];
    end
    for (int k = 0; k < NUM_DEST; k++) begin
      d_head_s[k]    = d_mem_r[k][d_rd_r[k]];
      empty_s[k]     = (d_cnt_r[k] == '0);
      d_pop_s[k]     = xfer_en_s && pop_d[k] && !empty_s[k];
      d_push_ok_s[k] = grant_valid_s && (grant_dest_s == DEST_BITS'(k)) &&
                       ((d_cnt_r[k] != D_FULL) || d_pop_s[k]);
      err_set_s[1+NUM_VC+k] = (xfer_en_s && pop_d[k] && empty_s[k]) ||
                              (grant_valid_s && (grant_dest_s == DEST_BITS'(k)) &&
                               (d_cnt_r[k] == D_FULL) && !d_pop_s[k]);
      any_ne_s       = any_ne_s || !empty_s[k];
    end
  end

  // Control FSM next-state; a latched error overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (|error_r) begin
      state_nxt_s = ST_ERROR;
    end else begin
      case (state_r)
        ST_RESET:  state_nxt_s = ST_INIT;
        ST_INIT:   state_nxt_s = init ? ST_INIT : ST_IDLE;
        ST_IDLE:   state_nxt_s = init ? ST_INIT : (any_ne_s ? ST_ACTIVE : ST_IDLE);
        ST_ACTIVE: state_nxt_s = init ? ST_INIT : (any_ne_s ? ST_ACTIVE : ST_IDLE);
        ST_ERROR:  state_nxt_s = ST_ERROR;
        default:   state_nxt_s = ST_ERROR;
      endcase
    end
  end

  // Control state, thresholds, FIFO pointers/counts and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RESET;
      af_main_r  <= (MA_W+1)'(MAIN_DEPTH-1);
      af_vc_r    <= (VA_W+1)'(VC_DEPTH-1);
      af_d_r     <= (DA_W+1)'(D_DEPTH-1);
      main_rd_r  <= '0;
      main_wr_r  <= '0;
      main_cnt_r <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        vc_rd_r[v]  <= '0;
        vc_wr_r[v]  <= '0;
        vc_cnt_r[v] <= '0;
      end
      for (int k = 0; k < NUM_DEST; k++) begin
        d_rd_r[k]  <= '0;
        d_wr_r[k]  <= '0;
        d_cnt_r[k] <= '0;
      end
      rr_ptr_r   <= '0;
      pause_r    <= 1'b0;
      data_out_r <= '0;
      valid_r    <= '0;
      error_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_INIT) && init) begin
        af_main_r <= af_main_i;
        af_vc_r   <= af_vc_i;
        af_d_r    <= af_d_i;
      end
      if (main_push_ok_s) main_wr_r <= main_wr_r + MA_W'(1);
      if (main_pop_s)     main_rd_r <= main_rd_r + MA_W'(1);
      main_cnt_r <= main_cnt_r + (MA_W+1)'(main_push_ok_s) - (MA_W+1)'(main_pop_s);
      for (int v = 0; v < NUM_VC; v++) begin
        if (vc_push_ok_s[v]) vc_wr_r[v] <= vc_wr_r[v] + VA_W'(1);
        if (vc_pop_s[v])     vc_rd_r[v] <= vc_rd_r[v] + VA_W'(1);
        vc_cnt_r[v] <= vc_cnt_r[v] + (VA_W+1)'(vc_push_ok_s[v]) - (VA_W+1)'(vc_pop_s[v]);
      end
      for (int k = 0; k < NUM_DEST; k++) begin
        if (d_push_ok_s[k]) d_wr_r[k] <= d_wr_r[k] + DA_W'(1);
        if (d_pop_s[k]) begin
          d_rd_r[k] <= d_rd_r[k] + DA_W'(1);
          data_out_r[k*DATA_W +: DATA_W] <= d_head_s[k];
        end
        d_cnt_r[k] <= d_cnt_r[k] + (DA_W+1)'(d_push_ok_s[k]) - (DA_W+1)'(d_pop_s[k]);
      end
      if (grant_valid_s) rr_ptr_r <= grant_vc_s + VC_BITS'(1);
      pause_r <= (main_cnt_r >= af_main_r);
      valid_r <= d_pop_s;
      error_r <= error_r | err_set_s;
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (main_push_ok_s) main_mem_r[main_wr_r] <= data_in;
    for (int v = 0; v < NUM_VC; v++) begin
      if (vc_push_ok_s[v]) vc_mem_r[v][vc_wr_r[v]] <= main_head_s;
    end
    for (int k = 0; k < NUM_DEST; k++) begin
      if (d_push_ok_s[k]) d_mem_r[k][d_wr_r[k]] <= grant_word_s;
    end
  end

  assign pause      = pause_r;
  assign empty_d    = empty_s;
  assign data_out   = data_out_r;
  assign valid_out  = valid_r;
  assign error_out  = error_r;
  assign state_out  = state_r;
  assign active_out = (state_r == ST_ACTIVE);
  assign idle_out   = (state_r == ST_IDLE);
endmodule

// File: tb/tb_vc_switch.sv
// Directed bench for vc_switch with default parameters (2 VCs, 2 destinations).
module tb_vc_switch;
  logic        clk = 1'b0;
  logic        reset, init, push_main;
  logic [3:0]  af_main_i;
  logic [4:0]  af_vc_i;
  logic [2:0]  af_d_i;
  logic [5:0]  data_in;
  logic [1:0]  pop_d;
  logic        pause;
  logic [1:0]  empty_d;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic [4:0]  error_out;
  logic [2:0]  state_out;
  logic        active_out, idle_out;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  vc_switch dut (
    .clk(clk), .reset(reset), .init(init),
    .af_main_i(af_main_i), .af_vc_i(af_vc_i), .af_d_i(af_d_i),
    .data_in(data_in), .push_main(push_main), .pop_d(pop_d),
    .pause(pause), .empty_d(empty_d), .data_out(data_out), .valid_out(valid_out),
    .error_out(error_out), .state_out(state_out),
    .active_out(active_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [5:0] w);
    data_in   = w;
    push_main = 1'b1;
    tick();
    push_main = 1'b0;
  endtask

  // Reset two cycles, RESET->INIT, latch thresholds for one INIT cycle, then go to IDLE.
  task automatic bring_up(input logic [3:0] am, input logic [4:0] av, input logic [2:0] ad);
    reset = 1'b1; init = 1'b0; push_main = 1'b0; pop_d = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    af_main_i = am; af_vc_i = av; af_d_i = ad; init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  // Pop destination k whenever it holds data and compare words with exp_q in order.
  task automatic drain(input int k, input string tag);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      pop_d    = 2'b00;
      pop_d[k] = !empty_d[k];
      tick();
      if (valid_out[k]) check(tag, 32'(data_out[k*6 +: 6]), 32'(exp_q.pop_front()));
    end
    pop_d = 2'b00;
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; push_main = 1'b0; pop_d = 2'b00; data_in = 6'd0;
    af_main_i = 4'd7; af_vc_i = 5'd15; af_d_i = 3'd3;

    // Reset values and single-word latency
    tick(); tick();
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_err", 32'(error_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_active", 32'(active_out), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd0);
    check("rst_empty", 32'(empty_d), 32'd3);
    reset = 1'b0;
    tick();
    check("init_state", 32'(state_out), 32'd1);
    af_main_i = 4'd7; af_vc_i = 5'd15; af_d_i = 3'd3; init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check("idle_state", 32'(state_out), 32'd2);
    check("idle_flag", 32'(idle_out), 32'd1);
    push_word(6'b10_0101);
    check("sw_n_empty", 32'(empty_d), 32'd3);
    tick();
    check("sw_n1_empty", 32'(empty_d), 32'd3);
    check("sw_n1_active", 32'(active_out), 32'd1);
    tick();
    check("sw_n2_empty", 32'(empty_d), 32'd2);
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    check("sw_data", 32'(data_out[5:0]), 32'h25);
    check("sw_valid", 32'(valid_out), 32'd1);
    check("sw_empty_after", 32'(empty_d), 32'd3);
    tick();
    check("sw_valid_drop", 32'(valid_out), 32'd0);
    check("sw_data_hold", 32'(data_out[5:0]), 32'h25);
    check("sw_back_idle", 32'(idle_out), 32'd1);
    check("sw_err", 32'(error_out), 32'd0);

    // Round-robin: af_d=0 parks 4 words in each VC, then release with af_d=4.
    // rr_ptr is 0 after reset, so VC0 is granted first and the grants alternate.
    bring_up(4'd7, 5'd15, 3'd0);
    for (int i = 0; i < 4; i++) push_word(6'h10 + 6'(i));
    for (int i = 0; i < 4; i++) push_word(6'h30 + 6'(i));
    for (int i = 0; i < 6; i++) tick();
    check("rr_parked", 32'(empty_d), 32'd3);
    init = 1'b1;
    tick();
    check("rr_reinit", 32'(state_out), 32'd1);
    af_d_i = 3'd4;
    tick();
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(6'h10 + 6'(i));
      exp_q.push_back(6'h30 + 6'(i));
    end
    drain(1, "rr_word");
    check("rr_err", 32'(error_out), 32'd0);

    // Back-pressure: af_d=2 holds dest0 short of full; nothing is lost
    bring_up(4'd7, 5'd15, 3'd2);
    for (int i = 0; i < 6; i++) push_word(6'(i));
    for (int i = 0; i < 12; i++) tick();
    check("bp_empty", 32'(empty_d), 32'd2);
    check("bp_err", 32'(error_out), 32'd0);
    check("bp_pause", 32'(pause), 32'd0);
    check("bp_active", 32'(active_out), 32'd1);
    for (int i = 0; i < 6; i++) exp_q.push_back(6'(i));
    drain(0, "bp_word");
    check("bp_err_end", 32'(error_out), 32'd0);

    // Main overflow: af_vc=0 blocks routing, 9th push overflows
    bring_up(4'd7, 5'd0, 3'd3);
    data_in = 6'h05; push_main = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("ov_pause_7", 32'(pause), 32'd0);
    tick();
    check("ov_pause_8", 32'(pause), 32'd1);
    check("ov_err_8", 32'(error_out), 32'd0);
    tick();
    check("ov_err_9", 32'(error_out), 32'd1);
    check("ov_state_9", 32'(state_out), 32'd3);
    tick();
    check("ov_state_err", 32'(state_out), 32'd4);
    check("ov_active", 32'(active_out), 32'd0);
    tick(); tick();
    push_main = 1'b0;
    check("ov_err_hold", 32'(error_out), 32'd1);
    check("ov_pause_hold", 32'(pause), 32'd1);

    // Pop on empty destination 1
    bring_up(4'd7, 5'd15, 3'd3);
    pop_d = 2'b10;
    tick();
    pop_d = 2'b00;
    check("pe_err", 32'(error_out), 32'h10);
    check("pe_valid", 32'(valid_out), 32'd0);
    tick();
    check("pe_state", 32'(state_out), 32'd4);

    // Mid-flight reset with 5 words held back by af_d=0
    bring_up(4'd7, 5'd15, 3'd0);
    for (int i = 0; i < 5; i++) push_word(6'h11);
    check("mr_active", 32'(active_out), 32'd1);
    reset = 1'b1;
    tick();
    check("mr_state", 32'(state_out), 32'd0);
    check("mr_empty", 32'(empty_d), 32'd3);
    check("mr_err", 32'(error_out), 32'd0);
    reset = 1'b0;
    tick();
    check("mr_init", 32'(state_out), 32'd1);
    tick();
    tick();
    check("mr_idle", 32'(idle_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
